// File: rtl/scalu_rs_if.sv
// Dispatch, writeback broadcast and exers->scalu issue signals of the ALU reservation station.
// The slave modport is the station itself; master is the surrounding pipeline.
interface scalu_rs_if;
  logic        disp_valid;
  logic [4:0]  disp_op;
  logic [6:0]  disp_robid;
  logic [5:0]  disp_rd;
  logic        disp_op1_rdy;
  logic [6:0]  disp_op1_tag;
  logic [31:0] disp_op1;
  logic        disp_op2_rdy;
  logic [6:0]  disp_op2_tag;
  logic [31:0] disp_op2;
  logic        rs_full;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic        exers_scalu_issue;
  logic [4:0]  exers_scalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        scalu_stall;
  logic        rob_flush;

  modport master (
    output disp_valid, disp_op, disp_robid, disp_rd, disp_op1_rdy, disp_op1_tag, disp_op1,
           disp_op2_rdy, disp_op2_tag, disp_op2, wb_valid, wb_robid, wb_result,
           scalu_stall, rob_flush,
    input  rs_full, exers_scalu_issue, exers_scalu_op, exers_robid, exers_rd, exers_op1,
           exers_op2
  );

  modport slave (
    input  disp_valid, disp_op, disp_robid, disp_rd, disp_op1_rdy, disp_op1_tag, disp_op1,
           disp_op2_rdy, disp_op2_tag, disp_op2, wb_valid, wb_robid, wb_result,
           scalu_stall, rob_flush,
    output rs_full, exers_scalu_issue, exers_scalu_op, exers_robid, exers_rd, exers_op1,
           exers_op2
  );
endinterface

// File: rtl/scalu_rs.sv
// Age-ordered reservation station for the scalar ALU: compacted entries, index 0 oldest,
// operand capture from the writeback broadcast, oldest-ready issue honouring scalu_stall.
module scalu_rs #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input logic       clk,
  input logic       rst,
  scalu_rs_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic        r1;
    logic [6:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [6:0]  t2;
    logic [31:0] v2;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            woken [DEPTH+1];
  entry_t            sel_ent;
  entry_t            new_ent;
  logic [CNTW-1:0]   count_q, count_d, widx;
  logic              full_q, full_d;
  logic              found, consume, accept;
  int                sel_idx;

  // Oldest ready entry, from registered state only.
  always_comb begin
    found   = 1'b0;
    sel_idx = 0;
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2) begin
        found   = 1'b1;
        sel_idx = i;
        sel_ent = ent_q[i];
      end
    end
  end

  assign consume = found & ~bus.scalu_stall;
  assign accept  = bus.disp_valid & ~full_q;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.op    = bus.disp_op;
    new_ent.robid = bus.disp_robid;
    new_ent.rd    = bus.disp_rd;
    new_ent.t1    = bus.disp_op1_tag;
    new_ent.t2    = bus.disp_op2_tag;
    new_ent.r1    = bus.disp_op1_rdy;
    new_ent.v1    = bus.disp_op1;
    new_ent.r2    = bus.disp_op2_rdy;
    new_ent.v2    = bus.disp_op2;
    if (!bus.disp_op1_rdy && bus.wb_valid && bus.disp_op1_tag == bus.wb_robid) begin
      new_ent.r1 = 1'b1;
      new_ent.v1 = bus.wb_result;
    end
    if (!bus.disp_op2_rdy && bus.wb_valid && bus.disp_op2_tag == bus.wb_robid) begin
      new_ent.r2 = 1'b1;
      new_ent.v2 = bus.wb_result;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (bus.wb_valid && ent_q[i].valid) begin
        if (!ent_q[i].r1 && ent_q[i].t1 == bus.wb_robid) begin
          woken[i].r1 = 1'b1;
          woken[i].v1 = bus.wb_result;
        end
        if (!ent_q[i].r2 && ent_q[i].t2 == bus.wb_robid) begin
          woken[i].r2 = 1'b1;
          woken[i].v2 = bus.wb_result;
        end
      end
    end
    woken[DEPTH] = '0;

    // Close the gap left by the consumed entry; the top slot is refilled with an empty entry.
    for (int i = 0; i < DEPTH; i++) begin
      if (consume && i >= sel_idx) ent_d[i] = woken[i+1];
      else                         ent_d[i] = woken[i];
    end

    widx = count_q - {{(CNTW-1){1'b0}}, consume};
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && widx == CNTW'(i)) ent_d[i] = new_ent;
    end

    count_d = count_q + {{(CNTW-1){1'b0}}, accept} - {{(CNTW-1){1'b0}}, consume};
    if (bus.rob_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      count_d = '0;
    end
    full_d = (count_d == CNTW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign bus.rs_full           = full_q;
  assign bus.exers_scalu_issue = found;
  assign bus.exers_scalu_op    = sel_ent.op;
  assign bus.exers_robid       = sel_ent.robid;
  assign bus.exers_rd          = sel_ent.rd;
  assign bus.exers_op1         = sel_ent.v1;
  assign bus.exers_op2         = sel_ent.v2;

endmodule

// File: doc/scalu_rs.md
Name: scalu_rs

Overview:
- Reservation station feeding the single-cycle scalar ALU.
- Accepts renamed ALU ops from dispatch and holds up to DEPTH entries in age order.
- Captures missing source operands from the writeback broadcast.
- Issues the oldest ready entry on the exers->scalu interface and honours scalu_stall.

Parameters:
DEPTH, 8, number of entries (2..16)
CNTW, 4, width of the occupancy counter; must hold the value DEPTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
disp_valid  in  1  dispatch request this cycle
disp_op  in  5  ALU opcode
disp_robid  in  7  ROB id of the op
disp_rd  in  6  destination register
disp_op1_rdy  in  1  op1 value present
disp_op1_tag  in  7  producer robid of op1 when not ready
disp_op1  in  32  op1 value when ready
disp_op2_rdy  in  1  op2 value present
disp_op2_tag  in  7  producer robid of op2 when not ready
disp_op2  in  32  op2 value when ready
rs_full  out  1  no free entry; dispatch must not be presented
wb_valid  in  1  writeback broadcast valid
wb_robid  in  7  robid of the broadcast result
wb_result  in  32  broadcast value
exers_scalu_issue  out  1  issue valid
exers_scalu_op  out  5  issued opcode
exers_robid  out  7  issued robid
exers_rd  out  6  issued rd
exers_op1  out  32  issued op1
exers_op2  out  32  issued op2
scalu_stall  in  1  ALU cannot accept; issue not consumed
rob_flush  in  1  discard all entries

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - all entries invalid, count=0
  - rs_full=0 and exers_scalu_issue=0
  - all exers_* data outputs are 0
- Entry fields: valid, op, robid, rd, and for each source a rdy bit, a tag and a value.
- Age order: entries are kept compacted; index 0 is the oldest, and valid entries occupy indices 0..count-1.
- Ready: an entry is ready when valid & op1.rdy & op2.rdy, using registered state only.
- Issue selection:
  - exers_scalu_issue = any entry ready. This is combinational from registered state.
  - Data outputs come from the lowest-index ready entry.
  - Data outputs are 0 when no entry is ready.
- Consume: the selected entry is removed at the clock edge only when exers_scalu_issue & ~scalu_stall.
  - Entries above the removed entry shift down one index in the same edge.
  - While scalu_stall=1, issue and data may remain asserted. The same entry stays selected unless an older entry becomes ready.
- Wakeup: each cycle with wb_valid, every valid entry with rdy=0 and tag==wb_robid captures wb_result and sets rdy=1.
  - Both sources of one entry may wake on the same broadcast.
  - A woken entry is issuable from the next cycle (no same-cycle bypass to issue).
- Dispatch:
  - Accepted when disp_valid & ~rs_full.
  - Written at index count, or count-1 if a consume happens in the same cycle.
  - If a source has rdy=0 and its tag matches a concurrent wb_valid/wb_robid, it is stored with rdy=1 and value wb_result.
  - disp_valid while rs_full is ignored and is a protocol error upstream.
- Occupancy: rs_full = (count==DEPTH), registered. There is no dispatch-while-full bypass even if a consume occurs that cycle.
- Count update: count next = count + accept - consume.
- Flush: rob_flush has priority over dispatch, wakeup and consume.
  - Next cycle all entries are invalid and count=0.
  - A dispatch in the flush cycle is dropped.
  - exers_scalu_issue may be high during the flush cycle; the ALU discards it on rob_flush.
- Reset mid-operation behaves as flush plus zeroed outputs.
- Simultaneous dispatch, wakeup and consume in one cycle must all take effect.

Test Plan:
- Ready dispatch, idle ALU: op=3, robid=5, both operands ready (0x10, 0x20) in cycle 0 -> cycle 1 issue=1, robid=5, op1=0x10, op2=0x20; cycle 2 issue=0, count=0.
- Wakeup: dispatch robid=9 with op1 tag=4 not ready; wb_valid, robid=4, result=0xDEAD in cycle 3 -> issue in cycle 4 with op1=0xDEAD; no issue before cycle 4.
- Dispatch-time capture: dispatch op2 tag=7 in the same cycle as wb_robid=7, result=0x55 -> entry issues the next cycle with op2=0x55.
- Age order and stall: fill 8 ready entries (robids 0..7), hold scalu_stall=1 for 3 cycles -> rs_full=1, issue holds robid=0; release stall -> robids 0..7 issue in order on consecutive cycles, rs_full drops after the first consume.
- Older not ready: entry A (robid 1) waiting, entry B (robid 2) ready -> B issues first; A issues 1 cycle after its wakeup.
- Flush: 5 entries resident, assert rob_flush together with disp_valid -> next cycle count=0, rs_full=0, issue=0; the dispatched op never issues.
